lsu: RTL



---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores (F3_B/H/W/BU/HU)
//   - lsu_state_t: access sequencing states (IDLE, REQ, WAIT, RESP)
//   - lsu_size(): access size field of a funct3 (00 byte, 01 half, 10 word)
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic [1:0] lsu_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for one transfer direction.
//   LOAD = 0 (store): din is rs2 data, dout is the lane-replicated bus word.
//   LOAD = 1 (load) : din is the bus read word, dout is the selected byte or
//                     half shifted down to bit 0 and sign/zero-extended.
//   be is the set of byte lanes touched by the access in both directions.
// Ports:
//   funct3 in 3  : RV32I load/store funct3
//   off    in 2  : byte offset within the word, already naturally aligned
//   din    in 32 : data to steer
//   dout   out 32: steered data
//   be     out 4 : byte lanes touched
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [3:0]  be
);

    logic [31:0] shifted;

    always_comb begin
        be      = 4'h0;
        dout    = '0;
        shifted = din >> {off, 3'b000};

        case (lsu_size(funct3))
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'hF;
        endcase

        if (LOAD) begin
            case (funct3)
                F3_B:    dout = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:    dout = {{16{shifted[15]}}, shifted[15:0]};
                F3_BU:   dout = {24'h0, shifted[7:0]};
                F3_HU:   dout = {16'h0, shifted[15:0]};
                default: dout = din;
            endcase
        end else begin
            // Replicating the datum into every lane lets the byte enables
            // alone pick the destination, whatever the offset.
            case (lsu_size(funct3))
                SZ_B:    dout = {4{din[7:0]}};
                SZ_H:    dout = {2{din[15:0]}};
                default: dout = din;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit fed by the execute-stage ALU sum.
// Accepts one memory op when idle, issues one word-aligned bus access and
// returns a one-cycle response with extended load data or a fault flag.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the valid side holds its payload stable until that edge and
// never lowers valid early; ready may depend on state only.
//   req_valid/req_ready : pipeline -> LSU, ready only in IDLE
//   mem_valid/mem_ready : LSU -> bus, mem_valid high exactly while in REQ
//   mem_rvalid          : bus read return, sampled only in WAIT
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata   request
//   mem_valid/mem_ready/mem_addr/mem_we/mem_be/mem_wdata       bus request
//   mem_rvalid/mem_rdata                                       bus read data
//   rsp_valid/rsp_data/rsp_fault                               writeback
//   dbg_state                          current FSM state
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses fault without touching the bus; otherwise the offset is forced to
// natural alignment and the access proceeds.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_fault,
    output lsu_state_t      dbg_state
);

    if (XLEN != 32) begin : g_xlen_check
        $fatal(1, "lsu: only XLEN=32 is supported");
    end

    lsu_state_t state, state_nxt;

    // Access captured at acceptance; every bus output is derived from these.
    logic            cap_we;
    logic [2:0]      cap_f3;
    logic [1:0]      cap_off;
    logic [XLEN-3:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;

    logic            accept;
    logic            acc_fault;
    logic [1:0]      eff_off;

    logic [XLEN-1:0] st_data;
    logic [3:0]      st_be;
    logic [XLEN-1:0] ld_data;
    logic [3:0]      ld_be;

    assign accept    = (state == IDLE) && req_valid;
    assign dbg_state = state;
    assign mem_addr  = {cap_addr, 2'b00};
    assign mem_wdata = st_data;

    // Offset used for steering: sub-word sizes are forced onto their natural
    // boundary. With trapping enabled, a non-faulting access is already
    // aligned, so the masking never changes it.
    always_comb begin
        eff_off = 2'b00;
        case (lsu_size(req_funct3))
            SZ_B:    eff_off = req_addr[1:0];
            SZ_H:    eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    always_comb begin
        acc_fault = 1'b0;
        if (req_we) begin
            case (req_funct3)
                F3_B, F3_H, F3_W: acc_fault = 1'b0;
                default:          acc_fault = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: acc_fault = 1'b0;
                default:                        acc_fault = 1'b1;
            endcase
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (lsu_size(req_funct3) == SZ_H && req_addr[0])
            acc_fault = 1'b1;
        if (lsu_size(req_funct3) == SZ_W && req_addr[1:0] != 2'b00)
            acc_fault = 1'b1;
`endif
    end

    lsu_align #(.LOAD(1'b0)) u_store_align (
        .funct3 (cap_f3),
        .off    (cap_off),
        .din    (cap_wdata),
        .dout   (st_data),
        .be     (st_be)
    );

    lsu_align #(.LOAD(1'b1)) u_load_align (
        .funct3 (cap_f3),
        .off    (cap_off),
        .din    (mem_rdata),
        .dout   (ld_data),
        .be     (ld_be)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = acc_fault ? RESP : REQ;
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_we    = cap_we;
                mem_be    = cap_we ? st_be : ld_be;
                if (mem_ready) state_nxt = cap_we ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response data is only meaningful during RESP; it is cleared on the way
    // out so stores and faults naturally report zero on the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we    <= 1'b0;
            cap_f3    <= 3'b000;
            cap_off   <= 2'b00;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_off   <= eff_off;
            cap_addr  <= req_addr[XLEN-1:2];
            cap_wdata <= req_wdata;
            rsp_data  <= '0;
            rsp_fault <= acc_fault;
        end else if (state == WAIT && mem_rvalid) begin
            rsp_data  <= ld_data;
        end else if (state == RESP) begin
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
        end
    end

endmodule
